cmd_addr_dly_seq: RTL and testbench
===================================

Name: cmd_addr_dly_seq

Overview:
Parametrised delay-programming sequencer for the DDR3 command/address PHY.
- Holds one ODELAY value per command/address line in a local table.
- Sweeps every line through the existing dly_addr/dly_data/ld_delay load port, then issues a single set pulse.
- Sits between the software/register interface and the cmd/addr PHY. It replaces hand-sequenced per-line loads, and supports broadcast of one value to all lines, abort, and table readback.

Parameters:
ADDRESS_NUMBER, 15, number of DDR3 address lines (1..24); lines 0..ADDRESS_NUMBER-1.
DLY_WIDTH, 8, delay value width (3 LSB fine delay).
CMD_BASE, 24, dly_addr of first command line; command lines at CMD_BASE+k, k=0..7 = ba0,ba1,ba2,we,ras,cas,cke,odt.
SET_GAP, 2, idle cycles between last ld_delay and set (0..15).
Derived (localparam): LINES = ADDRESS_NUMBER+8; IDX_W = 5.

Ports:
clk_div  in  1  sequencer clock (PHY clk_div domain).
rst  in  1  asynchronous active-high reset.
wr_en  in  1  write table entry.
wr_idx  in  IDX_W  table index (0..LINES-1; address lines first, then command lines).
wr_data  in  DLY_WIDTH  value to store.
rd_idx  in  IDX_W  readback index.
rd_data  out  DLY_WIDTH  registered table[rd_idx].
start  in  1  begin sweep (accepted only when busy=0).
broadcast  in  1  sampled with start: use bcast_data for all lines instead of table.
bcast_data  in  DLY_WIDTH  broadcast value, sampled with start.
abort  in  1  terminate sweep.
busy  out  1  sweep in progress.
done  out  1  one-cycle pulse after successful set.
dly_data  out  DLY_WIDTH  to PHY delay data.
dly_addr  out  5  to PHY delay line select.
ld_delay  out  1  to PHY load strobe.
set  out  1  to PHY apply-all strobe.

Behaviour:
- One clock (clk_div); reset asynchronous, active-high.
- Reset: busy, done, ld_delay, set = 0; dly_data, dly_addr, rd_data = 0; all table entries = 0; FSM = IDLE; idx = 0.
- All outputs are registered.
- FSM states: IDLE, LOAD, GAP, SET.
- IDLE:
  - start=1 at edge N latches broadcast and bcast_data, sets idx=0, goes to LOAD.
  - busy=1 from cycle N+1.
- LOAD: each cycle drives ld_delay=1, dly_addr=map(idx), dly_data = bcast latch or table[idx].
  - idx increments each cycle; ld_delay is high for cycles N+1..N+LINES.
  - After idx=LINES-1: go to GAP if SET_GAP>0, else go to SET.
- GAP: ld_delay=0 for SET_GAP cycles (counter).
- SET: set=1 for one cycle (cycle N+LINES+SET_GAP+1), then IDLE.
  - Next cycle: busy=0, done=1 for one cycle.
- map(idx): idx<ADDRESS_NUMBER -> idx; otherwise -> CMD_BASE+(idx-ADDRESS_NUMBER), truncated to 5 bits.
- dly_data/dly_addr hold their last value when ld_delay=0.
- start while busy: ignored, no effect.
- start and abort in the same cycle from IDLE: abort wins; sweep does not start.
- abort while busy: at next edge FSM goes to IDLE.
  - ld_delay=0, set=0, busy=0; done is not pulsed.
  - Lines already loaded stay loaded in the PHY but are not applied.
- wr_en always accepted, including while busy. A sweep uses the table value present at that line's LOAD cycle. A write to the same index in the same cycle as its load is not visible until the next sweep.
- wr_idx>=LINES: write dropped. rd_idx>=LINES: rd_data=0.
- rd_data latency: 1 cycle. A write followed by a read of the same index returns the new value on the second cycle.
- Reset mid-sweep: immediate return to reset values; no set is issued.

Decomposition:
- Package cmd_addr_pkg:
  - CMD_BASE default;
  - command-line offsets (CMD_BA0..CMD_ODT = 0..7);
  - FSM state encoding;
  - IDX_W.
- One sub-module, cmd_addr_dly_table:
  - LINES x DLY_WIDTH register file with async reset;
  - write port; combinational sweep read port; registered readback port.
- Sequencer FSM, counters and map() live in the top.

Test Plan:
- Defaults. Write table[i]=i+1 for i=0..22. Pulse start at edge 0 (broadcast=0) -> ld_delay high cycles 1..23:
  - dly_addr 0..14 with dly_data 1..15;
  - then dly_addr 24..31 with dly_data 16..23;
  - set=1 at cycle 26, done=1 at cycle 27;
  - busy high cycles 1..26.
- Broadcast: start with broadcast=1, bcast_data=0x5A -> all 23 loads carry 0x5A; table unchanged (readback of idx 3 = 4).
- Abort asserted at cycle 10 of a sweep -> ld_delay=0 from cycle 11, set never asserted, done=0, busy=0 at cycle 11. A following start runs a full sweep.
- start re-asserted at cycle 5 while busy -> ignored; exactly 23 ld_delay pulses and one set.
- Write 0xFF to idx 20 at cycle 3 of a sweep -> line 20 (dly_addr 29, load cycle 21) gets 0xFF.
- Write to idx 23 -> dropped; rd_idx=23 returns 0.
- rst pulsed at cycle 12 -> all outputs 0 immediately, table cleared (readback idx 0 = 0), no set.
- ADDRESS_NUMBER=13, SET_GAP=0 build: start -> 21 loads, address lines 0..12 then 24..31, set at cycle 22, done at cycle 23.

Source files
------------

// File: rtl/cmd_addr_pkg.sv
// Shared definitions for the cmd/addr delay-programming sequencer:
// index width, command-line layout and sequencer state encoding.
package cmd_addr_pkg;

  // Width of table / sweep indices (covers up to 32 lines).
  localparam int IDX_W = 5;

  // Default PHY delay address of the first command line.
  localparam int CMD_BASE_DEF = 24;

  // Command-line offsets relative to CMD_BASE.
  localparam int CMD_BA0 = 0;
  localparam int CMD_BA1 = 1;
  localparam int CMD_BA2 = 2;
  localparam int CMD_WE  = 3;
  localparam int CMD_RAS = 4;
  localparam int CMD_CAS = 5;
  localparam int CMD_CKE = 6;
  localparam int CMD_ODT = 7;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GAP  = 2'd2,
    ST_SET  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/cmd_addr_dly_table.sv
// Per-line delay value table: one write port, a combinational port used
// by the sweep, and a registered readback port for software.
module cmd_addr_dly_table
  import cmd_addr_pkg::*;
#(
  parameter int LINES     = 23,
  parameter int DLY_WIDTH = 8
) (
  input  logic                 clk_div,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [DLY_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]     sw_idx,
  output logic [DLY_WIDTH-1:0] sw_data,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [DLY_WIDTH-1:0] rd_data
);

  logic [DLY_WIDTH-1:0] mem_r [LINES];
  logic [DLY_WIDTH-1:0] rd_data_r;

  // Table storage: writes to indices beyond the table are dropped.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin
        mem_r[i] <= {DLY_WIDTH{1'b0}};
      end
    end else if (wr_en && (int'(wr_idx) < LINES)) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  // Sweep read: current stored value, so a same-cycle write is not seen.
  always_comb begin
    sw_data = {DLY_WIDTH{1'b0}};
    if (int'(sw_idx) < LINES) begin
      sw_data = mem_r[sw_idx];
    end else begin
      sw_data = {DLY_WIDTH{1'b0}};
    end
  end

  // Registered readback; out-of-range indices read as zero.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      rd_data_r <= {DLY_WIDTH{1'b0}};
    end else if (int'(rd_idx) < LINES) begin
      rd_data_r <= mem_r[rd_idx];
    end else begin
      rd_data_r <= {DLY_WIDTH{1'b0}};
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/cmd_addr_dly_seq.sv
// Delay-programming sequencer for the DDR3 cmd/addr PHY. Walks every
// address and command line through the ld_delay port (table or broadcast
// value), waits SET_GAP idle cycles and then issues one set strobe.
// Outputs are registered from the next-state decode so that the load of
// line 0 appears in the cycle right after start is sampled.
module cmd_addr_dly_seq
  import cmd_addr_pkg::*;
#(
  parameter int ADDRESS_NUMBER = 15,
  parameter int DLY_WIDTH      = 8,
  parameter int CMD_BASE       = CMD_BASE_DEF,
  parameter int SET_GAP        = 2
) (
  input  logic                 clk_div,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [DLY_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [DLY_WIDTH-1:0] rd_data,
  input  logic                 start,
  input  logic                 broadcast,
  input  logic [DLY_WIDTH-1:0] bcast_data,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [DLY_WIDTH-1:0] dly_data,
  output logic [4:0]           dly_addr,
  output logic                 ld_delay,
  output logic                 set
);

  localparam int               LINES    = ADDRESS_NUMBER + CMD_ODT + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [3:0]       GAP_LAST = 4'((SET_GAP > 0) ? (SET_GAP - 1) : 0);

  // Table index to PHY delay line: address lines first, then command lines.
  function automatic logic [4:0] map_line(input logic [IDX_W-1:0] idx);
    logic [4:0] res;
    if (int'(idx) < ADDRESS_NUMBER) begin
      res = idx;
    end else begin
      res = 5'(CMD_BASE + int'(idx) - ADDRESS_NUMBER);
    end
    return res;
  endfunction

  seq_state_t           state_r, state_s;
  logic [IDX_W-1:0]     idx_r, idx_s;
  logic [3:0]           gap_cnt_r, gap_cnt_s;
  logic                 bcast_r, bcast_s;
  logic [DLY_WIDTH-1:0] bdata_r, bdata_s;
  logic [DLY_WIDTH-1:0] sw_data_s;
  logic [DLY_WIDTH-1:0] load_data_s;

  logic                 busy_r, done_r, ld_delay_r, set_r;
  logic [DLY_WIDTH-1:0] dly_data_r;
  logic [4:0]           dly_addr_r;

  cmd_addr_dly_table #(
    .LINES     (LINES),
    .DLY_WIDTH (DLY_WIDTH)
  ) u_table (
    .clk_div (clk_div),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .sw_idx  (idx_s),
    .sw_data (sw_data_s),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // Next-state, sweep index, gap counter and broadcast latch decode.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    gap_cnt_s = gap_cnt_r;
    bcast_s   = bcast_r;
    bdata_s   = bdata_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          state_s = ST_LOAD;
          idx_s   = {IDX_W{1'b0}};
          bcast_s = broadcast;
          bdata_s = bcast_data;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (idx_r == LAST_IDX) begin
          if (SET_GAP > 0) begin
            state_s   = ST_GAP;
            gap_cnt_s = 4'd0;
          end else begin
            state_s = ST_SET;
          end
        end else begin
          idx_s = idx_r + IDX_ONE;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (gap_cnt_r == GAP_LAST) begin
          state_s = ST_SET;
        end else begin
          gap_cnt_s = gap_cnt_r + 4'd1;
        end
      end
      ST_SET: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Value for the line about to be loaded: broadcast latch or table entry.
  always_comb begin
    load_data_s = sw_data_s;
    if (bcast_s) begin
      load_data_s = bdata_s;
    end else begin
      load_data_s = sw_data_s;
    end
  end

  // Sequencer state and registered PHY / status outputs.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idx_r      <= {IDX_W{1'b0}};
      gap_cnt_r  <= 4'd0;
      bcast_r    <= 1'b0;
      bdata_r    <= {DLY_WIDTH{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ld_delay_r <= 1'b0;
      set_r      <= 1'b0;
      dly_data_r <= {DLY_WIDTH{1'b0}};
      dly_addr_r <= 5'd0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      gap_cnt_r  <= gap_cnt_s;
      bcast_r    <= bcast_s;
      bdata_r    <= bdata_s;
      busy_r     <= (state_s != ST_IDLE);
      ld_delay_r <= (state_s == ST_LOAD);
      set_r      <= (state_s == ST_SET);
      // An abort landing on the set cycle still suppresses done.
      done_r     <= (state_r == ST_SET) && !abort;
      if (state_s == ST_LOAD) begin
        dly_addr_r <= map_line(idx_s);
        dly_data_r <= load_data_s;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign ld_delay = ld_delay_r;
  assign set      = set_r;
  assign dly_data = dly_data_r;
  assign dly_addr = dly_addr_r;

endmodule

// File: tb/tb_cmd_addr_dly_seq.sv
// Directed bench for cmd_addr_dly_seq: default build (15 address lines,
// gap 2) plus a second build with 13 address lines and no gap.
module tb_cmd_addr_dly_seq;

  logic clk_div = 1'b0;

  // Free-running sequencer clock.
  always #5 clk_div = ~clk_div;

  // Default build signals.
  logic       rst, wr_en, start, broadcast, abort;
  logic [4:0] wr_idx, rd_idx, dly_addr;
  logic [7:0] wr_data, rd_data, bcast_data, dly_data;
  logic       busy, done, ld_delay, set;

  // Second build signals.
  logic       rst2, wr_en2, start2, broadcast2, abort2;
  logic [4:0] wr_idx2, rd_idx2, dly_addr2;
  logic [7:0] wr_data2, rd_data2, bcast_data2, dly_data2;
  logic       busy2, done2, ld_delay2, set2;

  logic [7:0] tbl_m [32];
  int err_cnt = 0;
  int chk_cnt = 0;

  cmd_addr_dly_seq dut (
    .clk_div(clk_div), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(rd_data), .start(start), .broadcast(broadcast),
    .bcast_data(bcast_data), .abort(abort), .busy(busy), .done(done),
    .dly_data(dly_data), .dly_addr(dly_addr), .ld_delay(ld_delay), .set(set)
  );

  cmd_addr_dly_seq #(.ADDRESS_NUMBER(13), .SET_GAP(0)) dut2 (
    .clk_div(clk_div), .rst(rst2), .wr_en(wr_en2), .wr_idx(wr_idx2), .wr_data(wr_data2),
    .rd_idx(rd_idx2), .rd_data(rd_data2), .start(start2), .broadcast(broadcast2),
    .bcast_data(bcast_data2), .abort(abort2), .busy(busy2), .done(done2),
    .dly_data(dly_data2), .dly_addr(dly_addr2), .ld_delay(ld_delay2), .set(set2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_div);
    #1;
  endtask

  // Expected PHY line for table index i with n address lines (cmd base 24).
  function automatic logic [4:0] exp_line(input int i, input int n);
    return (i < n) ? 5'(i) : 5'(24 + i - n);
  endfunction

  // Sweep on the default build; start sampled at edge 0, cycles 1..30 checked.
  task automatic sweep1(input bit bc, input logic [7:0] bv, input int abort_at,
                        input int restart_at, input int wr_at);
    int  n_ld, n_set, n_done;
    bit  live;
    n_ld = 0; n_set = 0; n_done = 0;
    start = 1'b1; broadcast = bc; bcast_data = bv;
    tick;
    start = 1'b0; broadcast = 1'b0; bcast_data = 8'h00;
    for (int c = 1; c <= 30; c++) begin
      live = (abort_at == 0) || (c <= abort_at);
      check($sformatf("busy c%0d", c), busy, live && (c <= 26));
      check($sformatf("ld c%0d", c), ld_delay, live && (c <= 23));
      check($sformatf("set c%0d", c), set, live && (c == 26));
      check($sformatf("done c%0d", c), done, live && (c == 27));
      if (live && (c <= 23)) begin
        check($sformatf("addr c%0d", c), dly_addr, exp_line(c - 1, 15));
        check($sformatf("data c%0d", c), dly_data, bc ? bv : tbl_m[c - 1]);
      end else if (live && (c <= 26)) begin
        check($sformatf("addr hold c%0d", c), dly_addr, 5'd31);
      end
      n_ld   += int'(ld_delay);
      n_set  += int'(set);
      n_done += int'(done);
      abort = (c == abort_at);
      start = (c == restart_at);
      if (c == wr_at) begin
        wr_en = 1'b1; wr_idx = 5'd20; wr_data = 8'hFF; tbl_m[20] = 8'hFF;
      end
      tick;
      abort = 1'b0; start = 1'b0; wr_en = 1'b0;
    end
    check("ld count", n_ld, (abort_at != 0) ? abort_at : 23);
    check("set count", n_set, (abort_at != 0) ? 0 : 1);
    check("done count", n_done, (abort_at != 0) ? 0 : 1);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; broadcast = 1'b0; abort = 1'b0;
    wr_idx = 5'd0; rd_idx = 5'd0; wr_data = 8'h00; bcast_data = 8'h00;
    rst2 = 1'b1; wr_en2 = 1'b0; start2 = 1'b0; broadcast2 = 1'b0; abort2 = 1'b0;
    wr_idx2 = 5'd0; rd_idx2 = 5'd0; wr_data2 = 8'h00; bcast_data2 = 8'h00;
    for (int i = 0; i < 32; i++) tbl_m[i] = 8'h00;
    tick; tick;

    // Reset values.
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst ld", ld_delay, 1'b0);
    check("rst set", set, 1'b0);
    check("rst data", dly_data, 8'h00);
    check("rst addr", dly_addr, 5'd0);
    check("rst rd", rd_data, 8'h00);
    rst = 1'b0; rst2 = 1'b0;
    tick;

    // Fill table with i+1.
    for (int i = 0; i < 23; i++) begin
      wr_en = 1'b1; wr_idx = 5'(i); wr_data = 8'(i + 1); tbl_m[i] = 8'(i + 1);
      tick;
    end
    wr_en = 1'b0;
    rd_idx = 5'd3; tick;
    check("rd idx3", rd_data, 8'd4);

    // Default sweep, then broadcast sweep.
    sweep1(1'b0, 8'h00, 0, 0, 0);
    sweep1(1'b1, 8'h5A, 0, 0, 0);
    rd_idx = 5'd3; tick;
    check("rd idx3 after bcast", rd_data, 8'd4);

    // Abort at cycle 10, then a full sweep.
    sweep1(1'b0, 8'h00, 10, 0, 0);
    sweep1(1'b0, 8'h00, 0, 0, 0);

    // Start while busy is ignored.
    sweep1(1'b0, 8'h00, 0, 5, 0);

    // Mid-sweep write to idx 20 at cycle 3.
    sweep1(1'b0, 8'h00, 0, 0, 3);

    // Start and abort together from idle: no sweep.
    start = 1'b1; abort = 1'b1; tick;
    start = 1'b0; abort = 1'b0;
    check("st+ab busy", busy, 1'b0);
    check("st+ab ld", ld_delay, 1'b0);
    tick;
    check("st+ab busy2", busy, 1'b0);

    // Out-of-range write dropped, out-of-range read returns zero.
    wr_en = 1'b1; wr_idx = 5'd23; wr_data = 8'hAA; tick;
    wr_en = 1'b0; rd_idx = 5'd23; tick;
    check("rd idx23", rd_data, 8'h00);
    rd_idx = 5'd22; tick;
    check("rd idx22", rd_data, 8'd23);

    // Write then read: old value first, new value on the second cycle.
    wr_en = 1'b1; wr_idx = 5'd7; wr_data = 8'h66; rd_idx = 5'd7; tick;
    wr_en = 1'b0; tbl_m[7] = 8'h66;
    check("rd old idx7", rd_data, 8'd8);
    tick;
    check("rd new idx7", rd_data, 8'h66);

    // Reset pulsed at cycle 12 of a sweep.
    start = 1'b1; tick; start = 1'b0;
    for (int c = 1; c < 12; c++) tick;
    check("pre-rst ld", ld_delay, 1'b1);
    rst = 1'b1; #1;
    check("mid-rst ld", ld_delay, 1'b0);
    check("mid-rst busy", busy, 1'b0);
    check("mid-rst addr", dly_addr, 5'd0);
    check("mid-rst data", dly_data, 8'h00);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) tbl_m[i] = 8'h00;
    begin
      int n_set;
      n_set = 0;
      for (int c = 0; c < 20; c++) begin
        n_set += int'(set) + int'(busy);
        tick;
      end
      check("post-rst set/busy", n_set, 0);
    end
    rd_idx = 5'd0; tick;
    check("post-rst rd idx0", rd_data, 8'h00);

    // Second build: 13 address lines, no gap.
    for (int i = 0; i < 21; i++) begin
      wr_en2 = 1'b1; wr_idx2 = 5'(i); wr_data2 = 8'(8'h80 + i);
      tick;
    end
    wr_en2 = 1'b0;
    start2 = 1'b1; tick; start2 = 1'b0;
    begin
      int n_ld;
      n_ld = 0;
      for (int c = 1; c <= 25; c++) begin
        check($sformatf("b2 busy c%0d", c), busy2, c <= 22);
        check($sformatf("b2 ld c%0d", c), ld_delay2, c <= 21);
        check($sformatf("b2 set c%0d", c), set2, c == 22);
        check($sformatf("b2 done c%0d", c), done2, c == 23);
        if (c <= 21) begin
          check($sformatf("b2 addr c%0d", c), dly_addr2, exp_line(c - 1, 13));
          check($sformatf("b2 data c%0d", c), dly_data2, 8'(8'h80 + c - 1));
        end
        n_ld += int'(ld_delay2);
        tick;
      end
      check("b2 ld count", n_ld, 21);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
